// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with fixed-format command frame parser
// Define UART_CMD_RX_CHK_EN to expect a CHK byte (CMD ^ ARG) between ARG and TAIL.
`timescale 1ns/1ps
module uart_cmd_rx #(
  parameter int CLK_FREQ  = 24_000_000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 20
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       cmd_valid,
  output logic [3:0] mode,
  output logic       frame_err
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int TO_CNT   = IDLE_BITS * BIT_CNT;
  localparam int CW       = $clog2(BIT_CNT + 1);
  localparam int TW       = $clog2(TO_CNT + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CNT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_CNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_END   = TW'(TO_CNT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] TAIL_BYTE = 8'h0A;
  localparam logic [7:0] MODE_CMD  = 8'h01;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_ARG, P_CHK, P_TAIL} p_state_t;

  rx_state_t      rx_state, rx_next;
  p_state_t       p_state, p_next;

  logic           rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           rx_fall, tick_half, tick_bit;
  logic           stop_ok, stop_bad;

  logic [7:0]     cmd_tmp, arg_tmp;
  logic [TW-1:0]  to_cnt;
  logic           timeout, accept, fail, latch_cmd, latch_arg;

  assign rx_fall   = rx_prev & ~rx_s2;
  assign tick_half = (cnt == HALF_END);
  assign tick_bit  = (cnt == BIT_END);

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_bit && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (tick_bit) begin
          rx_next  = RX_IDLE;
          stop_ok  = rx_s2;
          stop_bad = ~rx_s2;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // cnt sits at 1 in IDLE so the cycle after the start edge is count 1.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= CNT_ONE;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= stop_ok;
      if (stop_ok) byte_data <= shreg;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= CNT_ONE;
          bit_idx <= 3'd0;
        end
        RX_START: begin
          bit_idx <= 3'd0;
          cnt     <= tick_half ? CNT_ONE : cnt + CNT_ONE;
        end
        RX_DATA: begin
          if (tick_bit) begin
            cnt     <= CNT_ONE;
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {rx_s2, shreg[7:1]};
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: cnt <= tick_bit ? CNT_ONE : cnt + CNT_ONE;
      endcase
    end
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) p_state <= P_HDR;
    else        p_state <= p_next;
  end

  // A line error or inter-byte timeout abandons the frame before any byte is parsed.
  always_comb begin
    p_next    = p_state;
    accept    = 1'b0;
    fail      = 1'b0;
    latch_cmd = 1'b0;
    latch_arg = 1'b0;
    timeout   = (p_state != P_HDR) && !byte_valid && (to_cnt == TO_END);
    if (stop_bad || timeout) begin
      p_next = P_HDR;
    end else if (byte_valid) begin
      case (p_state)
        P_HDR: if (byte_data == HDR_BYTE) p_next = P_CMD;
        P_CMD: begin
          latch_cmd = 1'b1;
          p_next    = P_ARG;
        end
        P_ARG: begin
          latch_arg = 1'b1;
`ifdef UART_CMD_RX_CHK_EN
          p_next    = P_CHK;
`else
          p_next    = P_TAIL;
`endif
        end
`ifdef UART_CMD_RX_CHK_EN
        P_CHK: begin
          if (byte_data == (cmd_tmp ^ arg_tmp)) begin
            p_next = P_TAIL;
          end else begin
            fail   = 1'b1;
            p_next = P_HDR;
          end
        end
`endif
        P_TAIL: begin
          p_next = P_HDR;
          if (byte_data == TAIL_BYTE) accept = 1'b1;
          else                        fail   = 1'b1;
        end
        default: p_next = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      cmd_tmp   <= 8'h00;
      arg_tmp   <= 8'h00;
      to_cnt    <= '0;
      cmd       <= 8'h00;
      arg       <= 8'h00;
      cmd_valid <= 1'b0;
      mode      <= 4'd0;
      frame_err <= 1'b0;
    end else begin
      if (latch_cmd) cmd_tmp <= byte_data;
      if (latch_arg) arg_tmp <= byte_data;

      if (byte_valid)          to_cnt <= TO_ONE;
      else if (p_next == P_HDR) to_cnt <= '0;
      else                     to_cnt <= to_cnt + TO_ONE;

      cmd_valid <= accept;
      frame_err <= stop_bad | timeout | fail;
      if (accept) begin
        cmd <= cmd_tmp;
        arg <= arg_tmp;
        if (cmd_tmp == MODE_CMD) mode <= arg_tmp[3:0];
      end
    end
  end

endmodule
